// File: rtl/ov9281_pkg.sv
// Shared types for the OV9281 DVP capture path.
// FSM state encoding and pixel-packing helpers.
package ov9281_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOF,
        ACTIVE,
        DROP
    } capture_state_t;

    function automatic int ppw(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int ppw_cnt_w(input int data_width);
        return (ppw(data_width) > 1) ? $clog2(ppw(data_width)) : 1;
    endfunction

endpackage

// File: rtl/ov9281_capture_fifo.sv
// Show-ahead FIFO for packed capture words.
// Head entry is visible whenever empty is low.
module ov9281_capture_fifo #(
    parameter int  DEPTH   = 16,
    parameter type entry_t = logic [7:0]
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t wdata,
    input  logic   pop,
    output entry_t rdata,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two, at least 4");
    end

    entry_t mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic do_push;
    logic do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the slot, so a full push is still taken.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ov9281_capture.sv
// OV9281 DVP pixel capture: sync, pack, buffer and stream out.
// Frame/line statistics and sticky overflow reporting.
module ov9281_capture
    import ov9281_pkg::*;
#(
    parameter int CLK_SPEED  = 50000000,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int LINE_CNT_W = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_pclk,
    input  logic                  i_vsync,
    input  logic                  i_href,
    input  logic [7:0]            i_data,
    input  logic                  i_enable,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic                  o_tvalid,
    input  logic                  i_tready,
    output logic                  o_tuser,
    output logic                  o_tlast,
    output logic                  o_frame_done,
    output logic                  o_overflow,
    output logic [LINE_CNT_W-1:0] o_line_count,
    output logic [LINE_CNT_W-1:0] o_pixel_count
);

    localparam int PPW   = ppw(DATA_WIDTH);
    localparam int CNT_W = ppw_cnt_w(DATA_WIDTH);

    if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_dw
        $error("DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (CLK_SPEED < 4) begin : g_bad_clk
        $error("CLK_SPEED must allow PCLK <= CLK_SPEED/4");
    end

    typedef struct packed {
        logic [DATA_WIDTH-1:0] tdata;
        logic                  tuser;
        logic                  tlast;
    } fifo_entry_t;

    capture_state_t state;
    capture_state_t state_next;

    logic [2:0] pclk_q;
    logic [2:0] vsync_q;
    logic [2:0] href_q;
    logic [7:0] data_s1;
    logic [7:0] data_s2;
    logic [7:0] data_s3;

    logic pclk_rise;
    logic vs_rise;
    logic vs_fall;
    logic href_fall;
    logic pix_evt;
    logic line_end;
    logic sof;
    logic eof;

    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] acc_next;
    logic [CNT_W-1:0]      acc_cnt;
    logic                  acc_full;
    logic [DATA_WIDTH-1:0] held_word;
    logic                  held;
    logic                  first;
    logic [LINE_CNT_W-1:0] line_pix;

    logic        push_req;
    fifo_entry_t push_entry;
    fifo_entry_t rd_entry;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic        ovf_evt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pclk_q  <= '0;
            vsync_q <= '0;
            href_q  <= '0;
            data_s1 <= '0;
            data_s2 <= '0;
            data_s3 <= '0;
        end else begin
            pclk_q  <= {pclk_q[1:0], i_pclk};
            vsync_q <= {vsync_q[1:0], i_vsync};
            href_q  <= {href_q[1:0], i_href};
            data_s1 <= i_data;
            data_s2 <= data_s1;
            data_s3 <= data_s2;
        end
    end

    assign pclk_rise = pclk_q[1] & ~pclk_q[2];
    assign vs_rise   = vsync_q[1] & ~vsync_q[2];
    assign vs_fall   = ~vsync_q[1] & vsync_q[2];
    assign href_fall = ~href_q[1] & href_q[2];

    assign pix_evt  = (state == ACTIVE) & pclk_rise & href_q[1];
    assign line_end = (state == ACTIVE) & href_fall;

    assign pop     = ~fifo_empty & i_tready;
    assign ovf_evt = push_req & fifo_full & ~pop;

    always_comb begin
        state_next = state;
        sof        = 1'b0;
        eof        = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_enable) state_next = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (vs_fall) begin
                    sof        = i_enable;
                    state_next = i_enable ? ACTIVE : IDLE;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    eof        = 1'b1;
                    state_next = WAIT_SOF;
                end else if (ovf_evt) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (vs_rise) state_next = WAIT_SOF;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    assign acc_next = acc | (DATA_WIDTH'(data_s3) << {acc_cnt, 3'b000});
    assign acc_full = (acc_cnt == CNT_W'(PPW - 1));

    // Full words wait for the next pixel or HREF fall so tlast is known.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc        <= '0;
            acc_cnt    <= '0;
            held       <= 1'b0;
            held_word  <= '0;
            first      <= 1'b1;
            line_pix   <= '0;
            push_req   <= 1'b0;
            push_entry <= '0;
        end else begin
            push_req <= 1'b0;
            if (state_next != ACTIVE) begin
                acc      <= '0;
                acc_cnt  <= '0;
                held     <= 1'b0;
                first    <= 1'b1;
                line_pix <= '0;
            end else if (pix_evt) begin
                if (held) begin
                    push_req         <= 1'b1;
                    push_entry.tdata <= held_word;
                    push_entry.tuser <= first;
                    push_entry.tlast <= 1'b0;
                    first            <= 1'b0;
                end
                held <= acc_full;
                if (acc_full) begin
                    held_word <= acc_next;
                    acc       <= '0;
                    acc_cnt   <= '0;
                end else begin
                    acc     <= acc_next;
                    acc_cnt <= acc_cnt + 1'b1;
                end
                if (line_pix != '1) line_pix <= line_pix + 1'b1;
            end else if (line_end) begin
                if (acc_cnt != '0 || held) begin
                    push_req         <= 1'b1;
                    push_entry.tdata <= (acc_cnt != '0) ? acc : held_word;
                    push_entry.tuser <= first;
                    push_entry.tlast <= 1'b1;
                    first            <= 1'b0;
                end
                acc      <= '0;
                acc_cnt  <= '0;
                held     <= 1'b0;
                line_pix <= '0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_frame_done  <= 1'b0;
            o_overflow    <= 1'b0;
            o_line_count  <= '0;
            o_pixel_count <= '0;
        end else begin
            o_frame_done <= eof;
            if (sof)          o_overflow <= 1'b0;
            else if (ovf_evt) o_overflow <= 1'b1;
            if (sof) begin
                o_line_count <= '0;
            end else if (line_end && line_pix != '0) begin
                if (o_line_count != '1) o_line_count <= o_line_count + 1'b1;
                o_pixel_count <= line_pix;
            end
        end
    end

    ov9281_capture_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (fifo_entry_t)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (push_req),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (rd_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign o_tvalid = ~fifo_empty;
    assign o_tdata  = fifo_empty ? '0 : rd_entry.tdata;
    assign o_tuser  = ~fifo_empty & rd_entry.tuser;
    assign o_tlast  = ~fifo_empty & rd_entry.tlast;

endmodule
